// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC data-side bus controller:
// FSM encoding, MMIO register offsets and region-select helper.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAM_RD,
    RAM_WR,
    ACK
  } bus_state_t;

  localparam int OFF_OUT    = 'h0;
  localparam int OFF_SW     = 'h4;
  localparam int OFF_CYCLE  = 'h8;
  localparam int OFF_STATUS = 'hC;

  // The address MSB picks the region: 0 = RAM, 1 = MMIO.
  function automatic int region_bit(input int addr_w);
    return addr_w - 1;
  endfunction

endpackage

// File: rtl/soc_mmio_regs.sv
// MMIO register file: OUT, SW, CYCLE and STATUS registers,
// read mux and bad-offset error detection.
module soc_mmio_regs
  import soc_bus_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int SW_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-4:0] word_off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] be,
  input  logic [SW_W-1:0]   sw,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] reg32
);

  localparam int OW = ADDR_W - 1;

  logic [OW-1:0]     off;
  logic              sel_out;
  logic              sel_sw;
  logic              sel_cyc;
  logic              sel_st;
  logic              bad;
  logic [DATA_W-1:0] cycle;
  logic              err;

  assign off     = {word_off, 2'b00};
  assign sel_out = off == OW'(OFF_OUT);
  assign sel_sw  = off == OW'(OFF_SW);
  assign sel_cyc = off == OW'(OFF_CYCLE);
  assign sel_st  = off == OW'(OFF_STATUS);
  assign bad     = !(sel_out || sel_sw || sel_cyc || sel_st);

  // OUT register, byte lanes written under their enables
  always_ff @(posedge clk) begin
    if (rst) begin
      reg32 <= '0;
    end else if (wr_en && sel_out) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) reg32[8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Free-running cycle counter; a write clears it and wins over the increment
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle <= '0;
    end else if (wr_en && sel_cyc) begin
      cycle <= '0;
    end else begin
      cycle <= cycle + 1'b1;
    end
  end

  // Sticky error: set by any access to an unmapped offset, cleared by writing 1
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((wr_en || rd_en) && bad) begin
      err <= 1'b1;
    end else if (wr_en && sel_st && be[0] && wdata[0]) begin
      err <= 1'b0;
    end
  end

  // Read mux; unmapped offsets read as zero
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_out: rdata = reg32;
      sel_sw:  rdata[SW_W-1:0] = sw;
      sel_cyc: rdata = cycle;
      sel_st:  rdata[0] = err;
      default: ;
    endcase
  end

endmodule

// File: rtl/soc_data_bus.sv
// Data-side bus controller: request/ack handshake, RAM wait states,
// read-modify-write for partial stores, MMIO dispatch.
module soc_data_bus
  import soc_bus_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int SW_W     = 8,
  parameter int RAM_WAIT = 0
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iREQ,
  input  logic                iWE,
  input  logic [ADDR_W-1:0]   iADDR,
  input  logic [DATA_W-1:0]   iWDATA,
  input  logic [DATA_W/8-1:0] iBE,
  output logic [DATA_W-1:0]   oRDATA,
  output logic                oACK,
  output logic                oBUSY,
  output logic                oRAM_CE,
  output logic                oRAM_RD,
  output logic                oRAM_WR,
  output logic [ADDR_W-1:0]   oRAM_ADDR,
  output logic [DATA_W-1:0]   oRAM_DATA,
  input  logic [DATA_W-1:0]   iRAM_DATA,
  input  logic [SW_W-1:0]     iSW,
  output logic [DATA_W-1:0]   oREG32
);

  localparam int BE_W = DATA_W / 8;
  localparam int RB   = region_bit(ADDR_W);

  bus_state_t        state;
  bus_state_t        state_n;
  logic              accept;
  logic              is_mmio;
  logic              mmio_wr;
  logic              mmio_rd;
  logic [DATA_W-1:0] mmio_rdata;
  logic              we_q;
  logic [ADDR_W-1:2] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [3:0]        wait_q;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] merged;

  assign accept  = (state == IDLE) && iREQ;
  assign is_mmio = iADDR[RB];
  assign mmio_wr = accept && is_mmio && iWE;
  assign mmio_rd = accept && is_mmio && !iWE;

  soc_mmio_regs #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SW_W   (SW_W)
  ) u_mmio (
    .clk      (iCLK),
    .rst      (iRST),
    .wr_en    (mmio_wr),
    .rd_en    (mmio_rd),
    .word_off (iADDR[ADDR_W-2:2]),
    .wdata    (iWDATA),
    .be       (iBE),
    .sw       (iSW),
    .rdata    (mmio_rdata),
    .reg32    (oREG32)
  );

  // Partial-store merge: enabled lanes from the store, the rest from RAM
  always_comb begin
    merged = wdata_q;
    for (int i = 0; i < BE_W; i++) begin
      if (!be_q[i]) merged[8*i +: 8] = iRAM_DATA[8*i +: 8];
    end
  end

  // FSM state register
  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= state_n;
  end

  // Request capture, wait counting, read data and RAM write word
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      wait_q    <= '0;
      ram_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        we_q      <= iWE;
        addr_q    <= iADDR[ADDR_W-1:2];
        wdata_q   <= iWDATA;
        be_q      <= iBE;
        wait_q    <= 4'(RAM_WAIT);
        ram_wdata <= iWDATA;
      end
      if (mmio_rd) rdata_q <= mmio_rdata;
      if (state == RAM_RD) begin
        if (wait_q != '0) wait_q <= wait_q - 1'b1;
        else if (we_q)    ram_wdata <= merged;
        else              rdata_q <= iRAM_DATA;
      end
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_n = state;
    oRAM_CE = 1'b0;
    oRAM_RD = 1'b0;
    oRAM_WR = 1'b0;
    oACK    = 1'b0;
    unique case (state)
      IDLE: begin
        if (iREQ) begin
          if (is_mmio || (iWE && iBE == '0))  state_n = ACK;
          else if (!iWE || iBE != '1)         state_n = RAM_RD;
          else                                state_n = RAM_WR;
        end
      end
      RAM_RD: begin
        oRAM_CE = 1'b1;
        oRAM_RD = 1'b1;
        if (wait_q == '0) state_n = we_q ? RAM_WR : ACK;
      end
      RAM_WR: begin
        oRAM_CE = 1'b1;
        oRAM_WR = 1'b1;
        state_n = ACK;
      end
      ACK: begin
        oACK    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign oBUSY     = state != IDLE;
  assign oRAM_ADDR = {addr_q, 2'b00};
  assign oRAM_DATA = ram_wdata;
  assign oRDATA    = rdata_q;

endmodule
